// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared calculator types. num_t is the signed Q8.8 operand
//               and result word that every client and the adder exchange.
//               It also holds the adder-arbiter state encoding and the
//               completed-operation counter type.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

   localparam int NumW    = 16;   // total operand width
   localparam int NumFrac = 8;    // fractional bits (Q8.8)

   typedef logic [NumW-1:0] num_t;

   typedef logic [31:0] ops_count_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } alu_arb_state_e;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/alu_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_pick
// Description : Combinational round-robin picker. Scans the request vector
//               upward from last_grant+1 (modulo NumReq) and returns the
//               first requester found.
// Ports       : req        - request bit per requester
//               last_grant - index of the previous owner
//               any        - at least one request is present
//               g          - winning requester index (0 when any is low)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_pick #(
   parameter int NumReq = 4,
   parameter int IdW    = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdW-1:0]    last_grant,
   output logic              any,
   output logic [IdW-1:0]    g
);

   logic [IdW-1:0] idx;

   // Walk the offsets from farthest to nearest so the requester closest
   // after last_grant is the last one written and therefore wins.
   always_comb begin
      any = 1'b0;
      g   = '0;
      idx = '0;
      for (int i = NumReq; i >= 1; i--) begin
         idx = IdW'((int'(last_grant) + i) % NumReq);
         if (req[idx]) begin
            any = 1'b1;
            g   = idx;
         end
      end
   end

endmodule : alu_rr_pick
`default_nettype wire

// File: rtl/alu_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_add_arbiter
// Description : Shares one adder between NumReq requesters. Round-robin
//               grant, a single operation in flight, and the captured result
//               returned only to the requester that issued it.
// Ports       : clk_i/rst_ni        - clock, async active-low reset
//               req_left_i/right_i  - operands per requester
//               req_valid_i/ready_o - request handshake per requester
//               rsp_result_o        - captured sum (shared)
//               rsp_valid_o/ready_i - response handshake per requester
//               alu_left_o/right_o  - operands to the adder
//               alu_in_valid_o/in_ready_i   - adder input handshake
//               alu_result_i, alu_out_valid_i/out_ready_o - adder output
//               grant_id_o          - current or last owner
//               busy_o              - operation in progress
//               ops_done_o          - completed response handshakes
// Revision    : 1.0 - initial release
// ============================================================================
module alu_add_arbiter
   import calc_pkg::*;
#(
   parameter int NumReq = 4,
   parameter int IdW    = $clog2(NumReq)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,

   input  num_t [NumReq-1:0]     req_left_i,
   input  num_t [NumReq-1:0]     req_right_i,
   input  logic [NumReq-1:0]     req_valid_i,
   output logic [NumReq-1:0]     req_ready_o,

   output num_t                  rsp_result_o,
   output logic [NumReq-1:0]     rsp_valid_o,
   input  logic [NumReq-1:0]     rsp_ready_i,

   output num_t                  alu_left_o,
   output num_t                  alu_right_o,
   output logic                  alu_in_valid_o,
   input  logic                  alu_in_ready_i,
   input  num_t                  alu_result_i,
   input  logic                  alu_out_valid_i,
   output logic                  alu_out_ready_o,

   output logic [IdW-1:0]        grant_id_o,
   output logic                  busy_o,
   output ops_count_t            ops_done_o
);

   alu_arb_state_e state_q, state_d;

   num_t           op_left_q, op_right_q, result_q;
   logic [IdW-1:0] grant_q, last_grant_q;
   ops_count_t     ops_q;

   logic           pick_any;
   logic [IdW-1:0] pick_g;

   logic           accept, issue_hs, result_hs, rsp_hs;

   alu_rr_pick #(
      .NumReq (NumReq),
      .IdW    (IdW)
   ) u_pick (
      .req        (req_valid_i),
      .last_grant (last_grant_q),
      .any        (pick_any),
      .g          (pick_g)
   );

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and handshake outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d         = state_q;
      req_ready_o     = '0;
      rsp_valid_o     = '0;
      alu_in_valid_o  = 1'b0;
      alu_out_ready_o = 1'b0;
      accept          = 1'b0;
      issue_hs        = 1'b0;
      result_hs       = 1'b0;
      rsp_hs          = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               req_ready_o[pick_g] = 1'b1;
               accept              = 1'b1;
               state_d             = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            alu_in_valid_o = 1'b1;
            if (alu_in_ready_i) begin
               issue_hs = 1'b1;
               state_d  = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            alu_out_ready_o = 1'b1;
            if (alu_out_valid_i) begin
               result_hs = 1'b1;
               state_d   = ARB_RESP;
            end
         end
         ARB_RESP: begin
            rsp_valid_o[grant_q] = 1'b1;
            // Ready on any other lane is deliberately ignored.
            if (rsp_ready_i[grant_q]) begin
               rsp_hs  = 1'b1;
               state_d = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Operand, result, grant and counter registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_left_q    <= '0;
         op_right_q   <= '0;
         result_q     <= '0;
         grant_q      <= '0;
         last_grant_q <= IdW'(NumReq - 1);   // first grant goes to lane 0
         ops_q        <= '0;
      end else begin
         if (accept) begin
            op_left_q  <= req_left_i[pick_g];
            op_right_q <= req_right_i[pick_g];
            grant_q    <= pick_g;
         end
         if (result_hs) begin
            result_q <= alu_result_i;
         end
         if (rsp_hs) begin
            last_grant_q <= grant_q;
            ops_q        <= ops_q + 32'd1;
         end
      end
   end

   assign alu_left_o   = op_left_q;
   assign alu_right_o  = op_right_q;
   assign rsp_result_o = result_q;
   assign grant_id_o   = grant_q;
   assign busy_o       = (state_q != ARB_IDLE);
   assign ops_done_o   = ops_q;

   // issue_hs only documents the ISSUE->WAIT transfer; it needs no register.
   logic unused_issue_hs;
   assign unused_issue_hs = issue_hs;

endmodule : alu_add_arbiter
`default_nettype wire

// File: tb/tb_alu_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_add_arbiter
// Description : Self-checking bench for alu_add_arbiter. Plays the role of the
//               four requesters and of the shared adder (Q8.8 wrapping add
//               with programmable latency and input stall).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_add_arbiter;
   import calc_pkg::*;

   logic        clk;
   logic        rst_n;
   num_t [3:0]  req_left, req_right;
   logic [3:0]  req_valid, req_ready;
   num_t        rsp_result;
   logic [3:0]  rsp_valid, rsp_ready;
   num_t        alu_left, alu_right, alu_result;
   logic        alu_in_valid, alu_in_ready, alu_out_valid, alu_out_ready;
   logic [1:0]  grant_id;
   logic        busy;
   ops_count_t  ops_done;

   int n_checks = 0;
   int n_fail   = 0;

   alu_add_arbiter #(.NumReq(4)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .req_left_i      (req_left),
      .req_right_i     (req_right),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .rsp_result_o    (rsp_result),
      .rsp_valid_o     (rsp_valid),
      .rsp_ready_i     (rsp_ready),
      .alu_left_o      (alu_left),
      .alu_right_o     (alu_right),
      .alu_in_valid_o  (alu_in_valid),
      .alu_in_ready_i  (alu_in_ready),
      .alu_result_i    (alu_result),
      .alu_out_valid_i (alu_out_valid),
      .alu_out_ready_o (alu_out_ready),
      .grant_id_o      (grant_id),
      .busy_o          (busy),
      .ops_done_o      (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Adder model
   // ------------------------------------------------------------------------
   logic in_stall;
   int   add_lat;
   logic add_pend;
   int   add_cnt;
   num_t add_sum;
   int   in_hs_cnt = 0;

   assign alu_in_ready  = !add_pend && !in_stall;
   assign alu_out_valid = add_pend && (add_cnt == 0);
   assign alu_result    = add_sum;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_pend <= 1'b0;
         add_cnt  <= 0;
         add_sum  <= '0;
      end else if (alu_in_valid && alu_in_ready) begin
         add_pend  <= 1'b1;
         add_sum   <= alu_left + alu_right;
         add_cnt   <= add_lat;
         in_hs_cnt <= in_hs_cnt + 1;
      end else if (add_pend) begin
         if (add_cnt > 0)        add_cnt  <= add_cnt - 1;
         else if (alu_out_ready) add_pend <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [3:0] onehot(input int l);
      logic [3:0] v;
      v    = '0;
      v[l] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Waits (bounded) for rsp_valid; returns sampled 1 ns after a negedge.
   task automatic wait_rsp();
      int n = 0;
      while (rsp_valid == 4'b0 && n < 100) begin
         @(negedge clk); #1; n++;
      end
   endtask

   // One full operation for exp_lane. Entered at (or before) a negedge with
   // the request already driven; leaves at the negedge after the response
   // handshake so the next call can sample the new grant immediately.
   task automatic do_op(input int exp_lane, input bit drop);
      int   n = 0;
      num_t exp_sum;
      #1;
      while (req_ready == 4'b0 && n < 100) begin
         @(negedge clk); #1; n++;
      end
      check_eq("grant", req_ready, onehot(exp_lane));
      exp_sum = req_left[exp_lane] + req_right[exp_lane];
      @(posedge clk); #1;
      if (drop) req_valid[exp_lane] = 1'b0;
      wait_rsp();
      check_eq("rsp_lane", rsp_valid, onehot(exp_lane));
      check_eq("rsp_result", rsp_result, exp_sum);
      @(negedge clk);
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int   n;
      int   seen;
      int   base;
      int   hs;
      int   cyc;
      bit   pend;
      int   p_lane;
      num_t p_sum;

      rst_n     = 1'b0;
      req_left  = '0;
      req_right = '0;
      req_valid = '0;
      rsp_ready = 4'hF;
      in_stall  = 1'b0;
      add_lat   = 0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check_eq("rst_busy",      busy,          0);
      check_eq("rst_grant_id",  grant_id,      0);
      check_eq("rst_result",    rsp_result,    0);
      check_eq("rst_ops",       ops_done,      0);
      check_eq("rst_req_ready", req_ready,     0);
      check_eq("rst_rsp_valid", rsp_valid,     0);
      check_eq("rst_in_valid",  alu_in_valid,  0);
      check_eq("rst_out_ready", alu_out_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- single request: 1.5 + 2.25 = 3.75 ----
      req_left[0]  = 16'h0180;
      req_right[0] = 16'h0240;
      req_valid    = 4'b0001;
      do_op(0, 1'b1);
      check_eq("single_sum_const", rsp_result, 16'h03C0);
      check_eq("single_ops",       ops_done,   1);
      check_eq("single_grant_id",  grant_id,   0);

      // ---- round robin, all lanes valid, 8 operations ----
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_left[i]  = num_t'(16'h0040 + i * 16'h0100);
         req_right[i] = num_t'(16'h0080 + i);
      end
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) do_op(k % 4, 1'b0);
      check_eq("rr_ops", ops_done, 8);
      check_eq("rr_lane3_sum_const", 32'(req_left[3] + req_right[3]), 16'h03C3);

      // ---- adder back-pressure: 5 stalled cycles ----
      in_stall     = 1'b1;
      req_valid    = 4'b0010;
      req_left[1]  = 16'h1234;
      req_right[1] = 16'h0101;
      #1;
      check_eq("bp_grant", req_ready, 4'b0010);
      @(posedge clk); #1;
      req_valid = 4'b0;
      base = in_hs_cnt;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_eq("bp_in_valid", alu_in_valid, 1);
         check_eq("bp_operands", {alu_left, alu_right}, {16'h1234, 16'h0101});
      end
      check_eq("bp_no_hs_while_stalled", in_hs_cnt, base);
      in_stall = 1'b0;
      wait_rsp();
      check_eq("bp_one_hs", in_hs_cnt, base + 1);
      check_eq("bp_result", rsp_result, 16'h1335);
      @(negedge clk);

      // ---- response stall on lane 2 with lane 3 waiting ----
      rsp_ready    = 4'b1011;
      req_left[2]  = 16'h7F00;
      req_right[2] = 16'h0200;
      req_left[3]  = 16'h0010;
      req_right[3] = 16'h0020;
      req_valid    = 4'b1100;
      #1;
      check_eq("stall_grant2", req_ready, 4'b0100);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      wait_rsp();
      check_eq("stall_rsp_lane", rsp_valid, 4'b0100);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_eq("stall_result", rsp_result, 16'h8100);
         check_eq("stall_req_ready", req_ready, 0);
      end
      rsp_ready[2] = 1'b1;
      @(negedge clk); #1;
      check_eq("stall_grant3_next", req_ready, 4'b1000);
      do_op(3, 1'b1);
      check_eq("stall_lane3_sum", rsp_result, 16'h0030);

      // ---- reset during WAIT ----
      add_lat      = 20;
      req_left[0]  = 16'h0100;
      req_right[0] = 16'h0100;
      req_valid    = 4'b0001;
      #1;
      n = 0;
      while (req_ready == 4'b0 && n < 50) begin @(negedge clk); #1; n++; end
      @(posedge clk); #1;
      req_valid = 4'b0;
      n = 0;
      while (!alu_out_ready && n < 50) begin @(negedge clk); #1; n++; end
      check_eq("midwait_reached", alu_out_ready, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_busy",      busy,          0);
      check_eq("midrst_out_ready", alu_out_ready, 0);
      check_eq("midrst_left",      alu_left,      0);
      check_eq("midrst_result",    rsp_result,    0);
      check_eq("midrst_ops",       ops_done,      0);
      check_eq("midrst_rsp_valid", rsp_valid,     0);
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      add_lat = 1;
      seen    = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (rsp_valid != 4'b0 || busy) seen++;
      end
      check_eq("midrst_no_rsp_after", seen, 0);

      // ---- random soak ----
      hs   = 0;
      cyc  = 0;
      pend = 1'b0;
      p_lane = 0;
      p_sum  = '0;
      while (hs < 1000 && cyc < 40000) begin
         @(negedge clk);
         req_valid = 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            req_left[i]  = num_t'($urandom);
            req_right[i] = num_t'($urandom);
         end
         rsp_ready = 4'($urandom);
         in_stall  = ($urandom_range(0, 3) == 0);
         add_lat   = $urandom_range(0, 3);
         #1;
         // Response decision first: a grant cannot coexist with RESP.
         if ((rsp_valid & rsp_ready) != 4'b0) begin
            check_eq("soak_rsp_pending", pend, 1);
            check_eq("soak_rsp_lane", rsp_valid, onehot(p_lane));
            check_eq("soak_rsp_result", rsp_result, p_sum);
            pend = 1'b0;
            hs++;
         end
         if (req_ready != 4'b0) begin
            check_eq("soak_accept_idle", pend, 0);
            for (int i = 0; i < 4; i++) if (req_ready[i]) p_lane = i;
            check_eq("soak_grant_onehot", req_ready, onehot(p_lane));
            p_sum = req_left[p_lane] + req_right[p_lane];
            pend  = 1'b1;
         end
         cyc++;
      end
      check_eq("soak_hs_reached", hs, 1000);
      req_valid = 4'b0;
      @(negedge clk);
      check_eq("soak_ops_done", ops_done, hs);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_alu_add_arbiter
`default_nettype wire
